alu_mdu: RTL and testbench

Parametrised successor to the single-cycle MIPS ALU. It keeps the same one-cycle logic, arithmetic and compare operations, and adds an iterative multiply/divide unit (MDU) with architectural HI/LO registers. It sits in the EX stage of the MIPS datapath. The control unit launches MULT/MULTU/DIV/DIVU with `start` and stalls on `busy`; MFHI/MFLO read results back through `ALU_Out`.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/mdu_iter.sv | 114 +++++++++++
 rtl/alu_mdu.sv | 119 +++++++++++
 tb/tb_alu_mdu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode/state types for the ALU + iterative multiply/divide unit.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_XOR   = 4'b0011,
        OP_RSVD  = 4'b0100,
        OP_SLTU  = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_MULT  = 4'b1000,
        OP_MULTU = 4'b1001,
        OP_DIV   = 4'b1010,
        OP_DIVU  = 4'b1011,
        OP_NOR   = 4'b1100,
        OP_MFHI  = 4'b1101,
        OP_MFLO  = 4'b1110,
        OP_ZERO  = 4'b1111
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

    function automatic logic is_mdu_op(input alu_op_t op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative datapath: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, with the sign fix-up applied to the final step's result.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             step_done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] IDLE_CNT = CW'(WIDTH);

    // p holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               b_zero_q, b_zero_d;

    logic               is_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     r_shift;
    logic               ge;
    logic [WIDTH-1:0]   sub;
    logic [2*WIDTH-1:0] p_mul, p_div, p_step, prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        // op[1] selects divide, op[0] selects unsigned
        is_signed = ~op[0];
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        mag_a     = a_neg ? -a : a;
        mag_b     = b_neg ? -b : b;

        mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]}
                + {1'b0, (p_q[0] ? m_q : {WIDTH{1'b0}})};
        p_mul   = {mul_sum, p_q[WIDTH-1:1]};

        r_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        ge      = r_shift >= {1'b0, m_q};
        sub     = r_shift[WIDTH-1:0] - m_q;
        p_div   = {(ge ? sub : r_shift[WIDTH-1:0]), p_q[WIDTH-2:0], ge};

        p_step  = div_q ? p_div : p_mul;

        prod = neg_res_q ? -p_step : p_step;
        quo  = p_step[WIDTH-1:0];
        rem  = p_step[2*WIDTH-1:WIDTH];
        if (div_q) begin
            // divide-by-zero keeps the all-ones quotient regardless of signs
            res_lo = (neg_res_q & ~b_zero_q) ? -quo : quo;
            res_hi = neg_rem_q ? -rem : rem;
        end else begin
            res_lo = prod[WIDTH-1:0];
            res_hi = prod[2*WIDTH-1:WIDTH];
        end
        step_done = (cnt_q == LAST_CNT);

        p_d       = p_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
        if (load) begin
            p_d       = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
            m_d       = op[1] ? mag_b : mag_a;
            cnt_d     = '0;
            div_d     = op[1];
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            b_zero_d  = (b == '0);
        end else if (cnt_q != IDLE_CNT) begin
            p_d   = p_step;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q       <= '0;
            m_q       <= '0;
            cnt_q     <= IDLE_CNT;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
        end else begin
            p_q       <= p_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU: single-cycle logic/arith/compare ops plus a WIDTH-cycle
// multiply/divide unit writing the architectural HI/LO registers.
//
// state | meaning
// IDLE  | no MDU op in flight
// RUN   | mdu_iter stepping, busy high
// DONE  | HI/LO just written, done high; may accept a new start
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opCode,
    input  logic             start,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    alu_op_t          op;
    mdu_state_t       state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             load;
    logic             step_done;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign op = alu_op_t'(opCode);

    always_comb begin
        case (op)
            OP_AND:  ALU_Out = A & B;
            OP_OR:   ALU_Out = A | B;
            OP_XOR:  ALU_Out = A ^ B;
            OP_NOR:  ALU_Out = ~(A | B);
            OP_ADD:  ALU_Out = A + B;
            OP_SUB:  ALU_Out = A - B;
            OP_SLT:  ALU_Out = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: ALU_Out = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_MFHI: ALU_Out = hi_q;
            OP_MFLO: ALU_Out = lo_q;
            default: ALU_Out = '0;
        endcase
        zero = (ALU_Out == '0);
    end

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .op        (opCode[1:0]),
        .a         (A),
        .b         (B),
        .step_done (step_done),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (step_done) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                if (start && is_mdu_op(op)) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    load    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: vector tables, a behavioural arithmetic
// model, and hand-written multi-cycle sequences.
module tb_alu_mdu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [W-1:0] A, B;
    logic [3:0]   opCode;
    logic [W-1:0] ALU_Out, hi, lo;
    logic         zero, busy, done;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] cur_hi, cur_lo;

    alu_mdu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .opCode(opCode), .start(start),
        .ALU_Out(ALU_Out), .zero(zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b, y;
        logic         z;
    } alu_vec_t;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b, hi, lo;
    } mdu_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0011: return a ^ b;
            4'b1100: return ~(a | b);
            4'b0010: return W'(longint'(a) + longint'(b));
            4'b0110: return W'(longint'(a) - longint'(b));
            4'b0111: return (sa < sb) ? W'(1) : W'(0);
            4'b0101: return (longint'(a) < longint'(b)) ? W'(1) : W'(0);
            4'b1101: return cur_hi;
            4'b1110: return cur_lo;
            default: return '0;
        endcase
    endfunction

    // returns {hi, lo}
    function automatic logic [63:0] mdu_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (op)
            4'b1000: r = sa * sb;
            4'b1001: r = {32'b0, a} * {32'b0, b};
            4'b1010: if (b == 0) r = {a, {W{1'b1}}};
                     else r = {W'(sa % sb), W'(sa / sb)};
            4'b1011: if (b == 0) r = {a, {W{1'b1}}};
                     else r = {a % b, a / b};
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic launch(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        opCode = op; A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
        chk("done_after_start", 64'(done), 64'(0));
    endtask

    // Waits for done; in noisy mode scribbles on every input while running.
    task automatic finish_op(input logic [63:0] exp, input bit noisy);
        int lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (noisy) begin
                A = $urandom; B = $urandom;
                opCode = 4'(8 + $urandom_range(0, 3));
                start = $urandom_range(0, 1) == 1;
                if (lat == 5) begin
                    opCode = 4'b1110;
                    #1;
                    chk("mflo_mid_run", 64'(ALU_Out), 64'(cur_lo));
                end
            end
            chk("busy_running", 64'(busy), 64'(1));
            chk("hi_held", 64'(hi), 64'(cur_hi));
            tick();
            lat++;
        end
        start = 1'b0;
        chk("latency", 64'(lat), 64'(W));
        chk("busy_at_done", 64'(busy), 64'(0));
        cur_hi = exp[63:32];
        cur_lo = exp[31:0];
        chk("hi_result", 64'(hi), 64'(cur_hi));
        chk("lo_result", 64'(lo), 64'(cur_lo));
    endtask

    alu_vec_t av[11];
    mdu_vec_t mv[5];

    initial begin
        logic [63:0] e;
        logic [3:0]  op;
        logic [W-1:0] ra, rb;
        int          seen;

        av[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
        av[1]  = '{4'b0110, 32'd5,        32'd5,        32'h00000000, 1'b1};
        av[2]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
        av[3]  = '{4'b0101, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
        av[4]  = '{4'b1100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        av[5]  = '{4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0};
        av[6]  = '{4'b0001, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0};
        av[7]  = '{4'b0011, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1};
        av[8]  = '{4'b1111, 32'hDEADBEEF, 32'h00000001, 32'h00000000, 1'b1};
        av[9]  = '{4'b1000, 32'h00000003, 32'h00000007, 32'h00000000, 1'b1};
        av[10] = '{4'b1101, 32'h00000003, 32'h00000007, 32'h00000000, 1'b1};

        mv[0] = '{4'b1000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        mv[1] = '{4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        mv[2] = '{4'b1010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        mv[3] = '{4'b1011, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
        mv[4] = '{4'b1010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};

        reset = 1'b1; start = 1'b0; A = '0; B = '0; opCode = '0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        reset = 1'b0;
        cur_hi = '0;
        cur_lo = '0;
        tick();

        foreach (av[i]) begin
            opCode = av[i].op; A = av[i].a; B = av[i].b;
            #1;
            chk($sformatf("vec%0d_out", i), 64'(ALU_Out), 64'(av[i].y));
            chk($sformatf("vec%0d_zero", i), 64'(zero), 64'(av[i].z));
        end

        for (int i = 0; i < 100; i++) begin
            opCode = 4'($urandom_range(0, 15)); A = $urandom; B = $urandom;
            if (i % 4 == 0) B = A;
            #1;
            chk("rand_alu", 64'(ALU_Out), 64'(alu_ref(opCode, A, B)));
        end
        tick();

        foreach (mv[i]) begin
            launch(mv[i].op, mv[i].a, mv[i].b);
            finish_op({mv[i].hi, mv[i].lo}, 1'b0);
            tick();
            chk("done_single_pulse", 64'(done), 64'(0));
        end

        // start pulses and operand churn while running must not disturb the op
        launch(4'b1000, 32'hFFFFFFFD, 32'd7);
        finish_op(mdu_ref(4'b1000, 32'hFFFFFFFD, 32'd7), 1'b1);
        tick();
        chk("noisy_done_once", 64'(done), 64'(0));
        chk("noisy_idle", 64'(busy), 64'(0));

        // second op launched in the DONE cycle
        launch(4'b1011, 32'd1000, 32'd7);
        finish_op(mdu_ref(4'b1011, 32'd1000, 32'd7), 1'b0);
        launch(4'b1001, 32'd12345, 32'd678);
        finish_op(mdu_ref(4'b1001, 32'd12345, 32'd678), 1'b0);
        tick();
        chk("b2b_done_once", 64'(done), 64'(0));

        // reset in the middle of an iteration
        launch(4'b1010, 32'h12345678, 32'h00000123);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_hi", 64'(hi), 64'(0));
        chk("midrst_lo", 64'(lo), 64'(0));
        reset = 1'b0;
        cur_hi = '0;
        cur_lo = '0;
        seen = 0;
        repeat (40) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk("midrst_no_done", 64'(seen), 64'(0));

        for (int i = 0; i < 40; i++) begin
            op = 4'(8 + $urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 9));
                2: begin ra = 32'h80000000; rb = '1; end
                3: begin ra = W'($urandom_range(0, 50)); rb = 32'hFFFFFFFF - W'($urandom_range(0, 5)); end
                default: ;
            endcase
            launch(op, ra, rb);
            finish_op(mdu_ref(op, ra, rb), 1'b0);
            opCode = 4'b1101;
            #1;
            chk("rand_mfhi", 64'(ALU_Out), 64'(cur_hi));
            opCode = 4'b1110;
            #1;
            chk("rand_mflo", 64'(ALU_Out), 64'(cur_lo));
            if (i % 3 == 0) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
